// File: rtl/spark_ramp_ctrl.sv
// Ramp sequencer for one spark_pwm channel: walks the PWM ratio toward the host
// target in bounded steps, reverses only through zero, and guards the host and PWM links.
module spark_ramp_ctrl #(
  parameter int INTERVAL_W  = 16,
  parameter int WDOG_W      = 24,
  parameter int UPD_TIMEOUT = 8192
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ctrl_enable,
  input  logic                  cmd_valid,
  input  logic [7:0]            cmd_speed,
  input  logic                  cmd_dir,
  input  logic [7:0]            step_size,
  input  logic [INTERVAL_W-1:0] step_interval,
  input  logic [WDOG_W-1:0]     wdog_limit,
  input  logic                  pwm_done,
  output logic                  pwm_enable,
  output logic [7:0]            pwm_ratio,
  output logic                  pwm_direction,
  output logic                  pwm_update,
  output logic                  at_target,
  output logic                  busy,
  output logic                  wdog_fault,
  output logic                  update_err
);

  localparam int UPD_CNT_W = $clog2(UPD_TIMEOUT + 1);

  typedef enum logic [2:0] {OFF, STEP, UPDATE, WAIT, HOLD, DRAIN} state_t;

  state_t                state_q;
  logic [7:0]            cur_speed_q, tgt_speed_q, pwm_ratio_q;
  logic                  cur_dir_q, tgt_dir_q, pwm_direction_q;
  logic                  pwm_enable_q, pwm_update_q, wdog_fault_q, update_err_q;
  logic [WDOG_W-1:0]     wdog_cnt_q;
  logic [INTERVAL_W-1:0] dwell_q;
  logic [UPD_CNT_W-1:0]  upd_cnt_q;

  logic [7:0]            eff_speed;
  logic                  eff_dir;
  logic [8:0]            step_d;

  // Clamp a 9-bit decrement result: a borrow or anything below the floor lands on the floor.
  function automatic logic [7:0] sat_down(input logic [8:0] acc, input logic [7:0] floor);
    return (acc[8] || (acc[7:0] < floor)) ? floor : acc[7:0];
  endfunction

  // Clamp a 9-bit increment result at the ceiling; a carry is always above any 8-bit ceiling.
  function automatic logic [7:0] sat_up(input logic [8:0] acc, input logic [7:0] ceil);
    return (acc > {1'b0, ceil}) ? ceil : acc[7:0];
  endfunction

  // Returns {dir, speed} after one step toward (tgt, tdir).
  function automatic logic [8:0] next_step(input logic [7:0] cur, input logic cdir,
                                           input logic [7:0] tgt, input logic tdir,
                                           input logic [7:0] size);
    logic [8:0] s9;
    logic [7:0] spd;
    logic       dir;
    s9  = (size == 8'd0) ? 9'd1 : {1'b0, size};
    spd = cur;
    dir = cdir;
    if (cdir != tdir) begin
      if (cur != 8'd0) spd = sat_down({1'b0, cur} - s9, 8'd0);
      else             dir = tdir;
    end else if (cur < tgt) begin
      spd = sat_up({1'b0, cur} + s9, tgt);
    end else if (cur > tgt) begin
      spd = sat_down({1'b0, cur} - s9, tgt);
    end
    return {dir, spd};
  endfunction

  // While disabled the channel winds down in whatever direction it is already turning.
  assign eff_speed = ctrl_enable ? tgt_speed_q : 8'd0;
  assign eff_dir   = ctrl_enable ? tgt_dir_q   : cur_dir_q;
  assign step_d    = next_step(cur_speed_q, cur_dir_q, eff_speed, eff_dir, step_size);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= OFF;
      cur_speed_q     <= 8'd0;
      cur_dir_q       <= 1'b0;
      tgt_speed_q     <= 8'd0;
      tgt_dir_q       <= 1'b0;
      pwm_ratio_q     <= 8'd0;
      pwm_direction_q <= 1'b0;
      pwm_enable_q    <= 1'b0;
      pwm_update_q    <= 1'b0;
      wdog_fault_q    <= 1'b0;
      update_err_q    <= 1'b0;
      wdog_cnt_q      <= '0;
      dwell_q         <= '0;
      upd_cnt_q       <= '0;
    end else begin
      // A command arriving on the expiry cycle takes priority over the forced stop.
      if (cmd_valid) begin
        tgt_speed_q  <= cmd_speed;
        tgt_dir_q    <= cmd_dir;
        wdog_cnt_q   <= '0;
        wdog_fault_q <= 1'b0;
      end else if ((wdog_limit != '0) && ctrl_enable) begin
        if (wdog_cnt_q < wdog_limit) wdog_cnt_q <= wdog_cnt_q + 1'b1;
        if (wdog_cnt_q >= wdog_limit - 1'b1) begin
          tgt_speed_q  <= 8'd0;
          wdog_fault_q <= 1'b1;
        end
      end

      case (state_q)
        OFF: begin
          if (ctrl_enable) begin
            pwm_enable_q <= 1'b1;
            state_q      <= STEP;
          end
        end
        STEP: begin
          if (step_d == {cur_dir_q, cur_speed_q}) begin
            state_q <= HOLD;
          end else begin
            cur_dir_q       <= step_d[8];
            cur_speed_q     <= step_d[7:0];
            pwm_direction_q <= step_d[8];
            pwm_ratio_q     <= step_d[7:0];
            pwm_update_q    <= 1'b1;
            upd_cnt_q       <= '0;
            state_q         <= UPDATE;
          end
        end
        UPDATE: begin
          if (pwm_done) begin
            pwm_update_q <= 1'b0;
            dwell_q      <= step_interval;
            state_q      <= WAIT;
          end else if (upd_cnt_q == UPD_CNT_W'(UPD_TIMEOUT - 1)) begin
            update_err_q <= 1'b1;
            pwm_update_q <= 1'b0;
            state_q      <= HOLD;
          end else begin
            upd_cnt_q <= upd_cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (dwell_q == '0) state_q <= STEP;
          else               dwell_q <= dwell_q - 1'b1;
        end
        HOLD: begin
          if (!ctrl_enable && (cur_speed_q == 8'd0))
            state_q <= DRAIN;
          else if ((cur_speed_q != eff_speed) || (cur_dir_q != eff_dir))
            state_q <= STEP;
        end
        DRAIN: begin
          pwm_enable_q <= 1'b0;
          state_q      <= OFF;
        end
        default: state_q <= OFF;
      endcase
    end
  end

  assign pwm_enable    = pwm_enable_q;
  assign pwm_ratio     = pwm_ratio_q;
  assign pwm_direction = pwm_direction_q;
  assign pwm_update    = pwm_update_q;
  assign wdog_fault    = wdog_fault_q;
  assign update_err    = update_err_q;
  assign busy          = (state_q != OFF) && (state_q != HOLD);
  assign at_target     = (state_q == HOLD) && (cur_speed_q == eff_speed) && (cur_dir_q == eff_dir);

endmodule

// File: tb/tb_spark_ramp_ctrl.sv
// Bench for spark_ramp_ctrl: expected PWM updates are queued with each command and
// checked by a pwm_done responder as the design issues them.
module tb_spark_ramp_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_speed = 8'd0;
  logic        cmd_dir = 1'b0;
  logic [7:0]  step_size = 8'd16;
  logic [15:0] step_interval = 16'd10;
  logic [23:0] wdog_limit = 24'd0;
  logic        pwm_done;
  logic        pwm_enable, pwm_direction, pwm_update, at_target, busy, wdog_fault, update_err;
  logic [7:0]  pwm_ratio;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  exp_q[$];
  logic        auto_done = 1'b1;
  logic        upd_seen;

  spark_ramp_ctrl #(.INTERVAL_W(16), .WDOG_W(24), .UPD_TIMEOUT(8192)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_enable(ctrl_enable), .cmd_valid(cmd_valid),
    .cmd_speed(cmd_speed), .cmd_dir(cmd_dir), .step_size(step_size),
    .step_interval(step_interval), .wdog_limit(wdog_limit), .pwm_done(pwm_done),
    .pwm_enable(pwm_enable), .pwm_ratio(pwm_ratio), .pwm_direction(pwm_direction),
    .pwm_update(pwm_update), .at_target(at_target), .busy(busy),
    .wdog_fault(wdog_fault), .update_err(update_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic d);
    exp_q.push_back({d, r});
  endtask

  task automatic cmd(input logic [7:0] spd, input logic dir);
    @(negedge clock);
    cmd_speed = spd;
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    repeat (3) @(posedge clock);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "_idle"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_upd(input string tag);
    int n;
    n = 0;
    while (pwm_update !== 1'b1 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "_upd_seen"}, 32'(pwm_update), 32'd1);
  endtask

  // PWM model: checks each new update against the queue, answers 5 clocks later when enabled.
  initial begin : responder
    int dly;
    logic [8:0] e;
    pwm_done = 1'b0;
    upd_seen = 1'b0;
    dly = 0;
    forever begin
      @(posedge clock);
      #1;
      if (pwm_done) pwm_done = 1'b0;
      if (pwm_update !== 1'b1) begin
        upd_seen = 1'b0;
      end else if (!upd_seen) begin
        upd_seen = 1'b1;
        dly = 5;
        if (exp_q.size() == 0) begin
          chk("upd_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("upd_dir_ratio", 32'({pwm_direction, pwm_ratio}), 32'(e));
        end
      end
      if (upd_seen && auto_done && dly > 0) begin
        dly--;
        if (dly == 0) pwm_done = 1'b1;
      end
    end
  end

  initial begin : main
    int n;
    logic pb;

    repeat (3) @(negedge clock);
    chk("rst_outs", 32'({pwm_enable, pwm_ratio, pwm_direction, pwm_update,
                         at_target, busy, wdog_fault, update_err}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("off_enable", 32'(pwm_enable), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);

    ctrl_enable = 1'b1;
    repeat (4) @(negedge clock);
    chk("en_pwm_enable", 32'(pwm_enable), 32'd1);
    chk("en_at_target", 32'(at_target), 32'd1);

    // Ramp up 0 -> 100 in steps of 16
    for (int i = 1; i <= 6; i++) push(8'(16 * i), 1'b0);
    push(8'd100, 1'b0);
    cmd(8'd100, 1'b0);
    wait_idle("ramp");
    chk("ramp_ratio", 32'(pwm_ratio), 32'd100);
    chk("ramp_at_target", 32'(at_target), 32'd1);
    chk("ramp_q", 32'(exp_q.size()), 32'd0);

    // Down to 40, then reverse through zero
    step_size = 8'd20;
    step_interval = 16'd2;
    push(8'd80, 1'b0); push(8'd60, 1'b0); push(8'd40, 1'b0);
    cmd(8'd40, 1'b0);
    wait_idle("down40");
    push(8'd20, 1'b0); push(8'd0, 1'b0); push(8'd0, 1'b1); push(8'd20, 1'b1); push(8'd40, 1'b1);
    cmd(8'd40, 1'b1);
    wait_idle("rev");
    chk("rev_state", 32'({pwm_direction, pwm_ratio}), 32'({1'b1, 8'd40}));
    chk("rev_at_target", 32'(at_target), 32'd1);
    chk("rev_q", 32'(exp_q.size()), 32'd0);

    // Disable from 48 with step 16
    step_size = 8'd8;
    push(8'd48, 1'b1);
    cmd(8'd48, 1'b1);
    wait_idle("up48");
    step_size = 8'd16;
    push(8'd32, 1'b1); push(8'd16, 1'b1); push(8'd0, 1'b1);
    @(negedge clock);
    ctrl_enable = 1'b0;
    n = 0;
    pb = 1'b0;
    while (pwm_enable === 1'b1 && n < 3000) begin
      pb = busy;
      @(posedge clock);
      #1;
      n++;
    end
    chk("dis_done", 32'(n < 3000), 32'd1);
    chk("dis_drain_busy", 32'(pb), 32'd1);
    chk("dis_off_busy", 32'(busy), 32'd0);
    chk("dis_ratio", 32'(pwm_ratio), 32'd0);
    chk("dis_q", 32'(exp_q.size()), 32'd0);

    // Watchdog: ramp to 64, then go silent
    step_interval = 16'd10;
    for (int i = 1; i <= 4; i++) push(8'(16 * i), 1'b1);
    cmd(8'd64, 1'b1);
    @(negedge clock);
    ctrl_enable = 1'b1;
    wait_idle("wd_up");
    chk("wd_up_ratio", 32'(pwm_ratio), 32'd64);
    push(8'd48, 1'b1); push(8'd32, 1'b1); push(8'd16, 1'b1); push(8'd0, 1'b1);
    wdog_limit = 24'd1000;
    cmd(8'd64, 1'b1);
    n = 0;
    while (wdog_fault !== 1'b1 && n < 1100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("wdog_time", 32'(n), 32'd1000);
    wait_idle("wd_down");
    chk("wd_down_ratio", 32'(pwm_ratio), 32'd0);
    chk("wd_fault_sticky", 32'(wdog_fault), 32'd1);
    chk("wd_down_q", 32'(exp_q.size()), 32'd0);
    push(8'd16, 1'b1); push(8'd32, 1'b1);
    cmd(8'd32, 1'b1);
    chk("wd_fault_clear", 32'(wdog_fault), 32'd0);
    wdog_limit = 24'd0;
    wait_idle("wd_back");
    chk("wd_back_ratio", 32'(pwm_ratio), 32'd32);

    // Boundary: 253 -> 255 with step_size 0
    step_interval = 16'd3;
    step_size = 8'd221;
    push(8'd253, 1'b1);
    cmd(8'd253, 1'b1);
    wait_idle("to253");
    step_size = 8'd0;
    push(8'd254, 1'b1); push(8'd255, 1'b1);
    cmd(8'd255, 1'b1);
    wait_idle("to255");
    chk("top_ratio", 32'(pwm_ratio), 32'd255);
    chk("top_at_target", 32'(at_target), 32'd1);
    chk("top_q", 32'(exp_q.size()), 32'd0);

    // Handshake fault: pwm_done withheld
    auto_done = 1'b0;
    push(8'd254, 1'b1);
    cmd(8'd200, 1'b1);
    wait_upd("hs");
    n = 1;
    cmd(8'd254, 1'b1);
    if (pwm_update === 1'b1) n++;
    while (pwm_update === 1'b1 && n < 9000) begin
      @(posedge clock);
      #1;
      if (pwm_update === 1'b1) n++;
    end
    chk("hs_update_clocks", 32'(n), 32'd8192);
    chk("hs_update_err", 32'(update_err), 32'd1);
    chk("hs_update_low", 32'(pwm_update), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("hs_hold_busy", 32'(busy), 32'd0);
    chk("hs_ratio", 32'(pwm_ratio), 32'd254);

    // Asynchronous reset in the middle of an update
    push(8'd253, 1'b1);
    cmd(8'd250, 1'b1);
    wait_upd("ar");
    @(negedge clock);
    #2 reset_n = 1'b0;
    ctrl_enable = 1'b0;
    #1;
    chk("ar_outs", 32'({pwm_enable, pwm_ratio, pwm_direction, pwm_update,
                       at_target, busy, wdog_fault, update_err}), 32'd0);
    chk("ar_update", 32'(pwm_update), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    auto_done = 1'b1;
    repeat (3) @(negedge clock);
    chk("ar_idle_enable", 32'(pwm_enable), 32'd0);
    chk("final_q", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spark_ramp_ctrl.md
Name: spark_ramp_ctrl

Overview:
- Sequences one spark_pwm channel. The host issues speed/direction commands, and this block ramps the PWM ratio toward the target in bounded steps.
- Direction reversal always passes through ratio 0.
- Each step is handed to the PWM through the update/done handshake.
- A command watchdog forces a ramp to stop when the host goes silent. The block sits between the register/host interface and spark_pwm.

Parameters:
- INTERVAL_W, 16, width of the per-step dwell counter (clocks between steps).
- WDOG_W, 24, width of the command watchdog counter.
- UPD_TIMEOUT, 8192, clocks to wait for pwm_done before flagging update_err (twice the 4096-clock PWM frame).

Ports:
- clock  input  1  main clock
- reset_n  input  1  asynchronous active-low reset
- ctrl_enable  input  1  level; 1 = run, 0 = ramp to 0 then disable the PWM
- cmd_valid  input  1  single-cycle pulse; latch cmd_speed/cmd_dir as the new target
- cmd_speed  input  8  target magnitude 0..255
- cmd_dir  input  1  target direction
- step_size  input  8  ratio change per step; 0 is treated as 1
- step_interval  input  INTERVAL_W  dwell clocks after each applied step
- wdog_limit  input  WDOG_W  clocks without cmd_valid before the forced stop; 0 = watchdog off
- pwm_done  input  1  pulse from spark_pwm: the update was applied
- pwm_enable  output  1  to spark_pwm
- pwm_ratio  output  8  to spark_pwm
- pwm_direction  output  1  to spark_pwm
- pwm_update  output  1  to spark_pwm; held until pwm_done
- at_target  output  1  current speed/direction equal the target, and no step is pending
- busy  output  1  state is not OFF or HOLD
- wdog_fault  output  1  sticky; watchdog expired
- update_err  output  1  sticky; pwm_done not seen within UPD_TIMEOUT

Behaviour:
- Reset values:
  - All outputs are 0.
  - cur_speed=0, cur_dir=0, tgt_speed=0, tgt_dir=0, state=OFF.
- Target capture:
  - On cmd_valid, tgt_speed/tgt_dir are loaded in any state, and the watchdog counter and wdog_fault are cleared.
  - A cmd_valid arriving on the same cycle as watchdog expiry wins.
- Watchdog:
  - When wdog_limit != 0 and ctrl_enable = 1, the counter increments each clock.
  - When it reaches wdog_limit: tgt_speed <= 0, wdog_fault <= 1, and the counter holds.
- States:
  - OFF: pwm_enable=0. Go to STEP when ctrl_enable=1.
  - STEP: one cycle; pwm_enable=1. Compute the next cur_speed/cur_dir (rules below).
    - If the result equals the current values, go to HOLD.
    - Otherwise register pwm_ratio/pwm_direction and go to UPDATE.
  - UPDATE: pwm_update=1.
    - On pwm_done: drop pwm_update the next cycle, load the dwell counter with step_interval, and go to WAIT.
    - If UPD_TIMEOUT clocks elapse without pwm_done: set update_err, drop pwm_update, go to HOLD.
  - WAIT: decrement the dwell counter. At 0, go to STEP; with step_interval=0 this is the next cycle.
  - HOLD: pwm_enable=1.
    - When the target differs from current, go to STEP.
    - When ctrl_enable=0 and cur_speed=0, go to DRAIN.
  - DRAIN: one cycle; pwm_enable <= 0, then go to OFF.
- ctrl_enable=0 in any running state:
  - The effective target becomes speed 0 with direction unchanged.
  - The ramp continues down, and DRAIN occurs only once cur_speed=0.
  - An in-flight UPDATE always completes; pwm_update is never dropped before pwm_done or timeout.
- Step rules (effective target T, direction D, step s = max(step_size,1)):
  - If cur_dir != D and cur_speed > 0: cur_speed <= sat0(cur_speed - s).
  - If cur_dir != D and cur_speed = 0: cur_dir <= D, speed stays 0. This counts as a step and is sent to the PWM.
  - If cur_dir = D: move toward T by s, clamped so it never overshoots T.
  - All arithmetic is 9-bit to detect under/overflow, and the result saturates to 0..255.
- at_target: 1 in HOLD when cur == effective target, 0 elsewhere.
- A new cmd_valid during WAIT or UPDATE takes effect at the next STEP; the current step is not aborted.
- Asynchronous reset mid-operation returns every output to 0 immediately, including pwm_update and pwm_enable.

Test Plan:
- Ramp up: step_size=16, step_interval=10, cmd speed=100 dir=0; bench returns pwm_done 5 clocks after each pwm_update.
  - Required: pwm_ratio sequence 16,32,48,64,80,96,100; then HOLD with at_target=1.
- Reversal: from speed 40 dir 0, cmd speed 40 dir 1 with step 20.
  - Required: ratios 20, 0 with dir 0; then 0 with dir 1; then 20, 40 with dir 1. No update ever carries ratio>0 with the old direction after the reversal point.
- Watchdog: wdog_limit=1000, speed 64, no further commands.
  - Required: wdog_fault rises at 1000 clocks and the block ramps to 0.
  - A subsequent cmd_valid clears wdog_fault and ramps back.
- Disable: at speed 48 with step 16, drop ctrl_enable.
  - Required: ratios 32,16,0; then pwm_enable falls one cycle after DRAIN; busy=0 in OFF.
- Handshake fault: never return pwm_done.
  - Required: pwm_update stays high exactly UPD_TIMEOUT clocks, then update_err=1 and pwm_update=0.
- Boundary: step_size=0 and cmd speed 255 from 253.
  - Required: ratios 254, 255, with no wrap to 0.
  - Separately, assert reset_n low mid-UPDATE: all outputs go to 0 asynchronously.
